// File: rtl/square_drawer_if.sv
// Square drawer handshake / framebuffer bus.
//   go, loc_done, x_loc, y_loc        : driven by the requester and location picker
//   loc_start                         : location request to the picker
//   pixel_x, pixel_y, pixel_color,
//   pixel_write                       : framebuffer write port
//   busy, done                        : drawer status
// The master modport is the environment side; the slave modport is the drawer.
interface square_drawer_if;
  logic        go;
  logic        loc_start;
  logic        loc_done;
  logic [10:0] x_loc;
  logic [10:0] y_loc;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        pixel_color;
  logic        pixel_write;
  logic        busy;
  logic        done;

  modport master (
    output go, loc_done, x_loc, y_loc,
    input  loc_start, pixel_x, pixel_y, pixel_color, pixel_write, busy, done
  );

  modport slave (
    input  go, loc_done, x_loc, y_loc,
    output loc_start, pixel_x, pixel_y, pixel_color, pixel_write, busy, done
  );
endinterface

// File: rtl/square_drawer.sv
// Square drawer: on go, fetches a new top-left location from a location
// picker over a four-phase handshake, erases the previously drawn square (if
// any) and draws a SIZE x SIZE square at the new location, one pixel per
// cycle, clipping writes that fall off the visible screen.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : square_drawer_if.slave (request, picker handshake, pixel port, status)
module square_drawer #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic            clk,
  input  logic            reset,
  square_drawer_if.slave  bus
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CNT_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SIZE - 1);
  localparam logic [COORD_W:0]   SCR_W    = (COORD_W + 1)'(SCREEN_W);
  localparam logic [COORD_W:0]   SCR_H    = (COORD_W + 1)'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_ERASE,
    S_DRAW,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cx;
  logic [CNT_W-1:0]   r_cy;
  logic [COORD_W-1:0] r_new_x;
  logic [COORD_W-1:0] r_new_y;
  logic [COORD_W-1:0] r_prev_x;
  logic [COORD_W-1:0] r_prev_y;
  logic               r_have_prev;

  logic               r_loc_start;
  logic [COORD_W-1:0] r_pixel_x;
  logic [COORD_W-1:0] r_pixel_y;
  logic               r_pixel_color;
  logic               r_pixel_write;
  logic               r_busy;
  logic               r_done;

  logic               w_sweep;
  logic               w_last;
  logic [CNT_W-1:0]   w_cx_nxt;
  logic [CNT_W-1:0]   w_cy_nxt;
  logic               w_restart;
  logic               w_use_prev;
  logic [CNT_W-1:0]   w_off_x;
  logic [CNT_W-1:0]   w_off_y;
  logic [COORD_W-1:0] w_pix_x;
  logic [COORD_W-1:0] w_pix_y;
  logic               w_pix_on;

  // Sweep counter advance: cx inner loop, cy outer loop.
  assign w_sweep  = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_last   = (r_cx == CNT_LAST) && (r_cy == CNT_LAST);
  assign w_cx_nxt = (r_cx == CNT_LAST) ? '0 : r_cx + CNT_W'(1);
  assign w_cy_nxt = (r_cx == CNT_LAST) ? r_cy + CNT_W'(1) : r_cy;

  // Next pixel to present: the first pixel of a sweep when entering one
  // (from REL, or ERASE rolling into DRAW), otherwise the advanced counters.
  assign w_restart  = !w_sweep || w_last;
  assign w_use_prev = (r_state == S_REL) ? r_have_prev
                                         : ((r_state == S_ERASE) && !w_last);
  assign w_off_x    = w_restart ? '0 : w_cx_nxt;
  assign w_off_y    = w_restart ? '0 : w_cy_nxt;
  assign w_pix_x    = (w_use_prev ? r_prev_x : r_new_x) + COORD_W'(w_off_x);
  assign w_pix_y    = (w_use_prev ? r_prev_y : r_new_y) + COORD_W'(w_off_y);

  // Off-screen pixels still take their sweep cycle but do not write.
  assign w_pix_on   = ({1'b0, w_pix_x} < SCR_W) && ({1'b0, w_pix_y} < SCR_H);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cx          <= '0;
      r_cy          <= '0;
      r_new_x       <= '0;
      r_new_y       <= '0;
      r_prev_x      <= '0;
      r_prev_y      <= '0;
      r_have_prev   <= 1'b0;
      r_loc_start   <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_color <= 1'b0;
      r_pixel_write <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_pixel_write <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_state     <= S_REQ;
            r_loc_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.loc_done) begin
            r_new_x     <= bus.x_loc;
            r_new_y     <= bus.y_loc;
            r_loc_start <= 1'b0;
            r_state     <= S_REL;
          end
        end
        S_REL: begin
          // Wait for the picker to drop its acknowledge before sweeping.
          if (!bus.loc_done) begin
            r_state       <= r_have_prev ? S_ERASE : S_DRAW;
            r_cx          <= '0;
            r_cy          <= '0;
            r_pixel_x     <= w_pix_x;
            r_pixel_y     <= w_pix_y;
            r_pixel_color <= !r_have_prev;
            r_pixel_write <= w_pix_on;
          end
        end
        S_ERASE: begin
          r_pixel_x     <= w_pix_x;
          r_pixel_y     <= w_pix_y;
          r_pixel_write <= w_pix_on;
          if (w_last) begin
            r_state       <= S_DRAW;
            r_cx          <= '0;
            r_cy          <= '0;
            r_pixel_color <= 1'b1;
          end else begin
            r_cx          <= w_cx_nxt;
            r_cy          <= w_cy_nxt;
            r_pixel_color <= 1'b0;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state     <= S_FIN;
            r_cx        <= '0;
            r_cy        <= '0;
            r_prev_x    <= r_new_x;
            r_prev_y    <= r_new_y;
            r_have_prev <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_cx          <= w_cx_nxt;
            r_cy          <= w_cy_nxt;
            r_pixel_x     <= w_pix_x;
            r_pixel_y     <= w_pix_y;
            r_pixel_color <= 1'b1;
            r_pixel_write <= w_pix_on;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_loc_start <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.loc_start   = r_loc_start;
  assign bus.pixel_x     = r_pixel_x;
  assign bus.pixel_y     = r_pixel_y;
  assign bus.pixel_color = r_pixel_color;
  assign bus.pixel_write = r_pixel_write;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_square_drawer.sv
// Testbench for square_drawer: drives requests and the location picker,
// predicts every framebuffer write into a scoreboard queue and compares the
// writes the drawer produces against it.
module tb_square_drawer;

  localparam int unsigned SIZE = 16;
  localparam int unsigned SW   = 640;
  localparam int unsigned SH   = 480;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  square_drawer_if u_if ();

  square_drawer #(
    .SIZE     (SIZE),
    .SCREEN_W (SW),
    .SCREEN_H (SH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int n_chk = 0;
  int n_bad = 0;
  int n_done = 0;

  logic [22:0] exp_q[$];          // {color, x, y}
  bit          mdl_have_prev = 1'b0;
  logic [10:0] mdl_px = '0;
  logic [10:0] mdl_py = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected writes of one sweep, row-major, with screen clipping.
  function automatic void push_sweep(input logic [10:0] bx, input logic [10:0] by, input logic c);
    logic [10:0] x;
    logic [10:0] y;
    for (int cy = 0; cy < int'(SIZE); cy++) begin
      for (int cx = 0; cx < int'(SIZE); cx++) begin
        x = bx + 11'(cx);
        y = by + 11'(cy);
        if (32'(x) < SW && 32'(y) < SH) exp_q.push_back({c, x, y});
      end
    end
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk(tag, 32'({u_if.loc_start, u_if.pixel_x, u_if.pixel_y, u_if.pixel_color,
                  u_if.pixel_write, u_if.busy, u_if.done}), 32'd0);
  endtask

  // Monitor: every write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [22:0] e;
    if (reset === 1'b1) begin
      if (u_if.done === 1'b1) n_done++;
      if (u_if.pixel_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'({u_if.pixel_color, u_if.pixel_x, u_if.pixel_y}), 32'h7fffff);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'({u_if.pixel_color, u_if.pixel_x, u_if.pixel_y}), 32'(e));
        end
      end
    end
  end

  // One request: go pulse, picker answers after 'delay' cycles with (nx,ny),
  // holds loc_done 'hold' extra cycles after loc_start drops. Optionally pokes
  // go during DRAW, or resets the block 'abort_after' cycles into the sweep.
  task automatic do_req(input logic [10:0] nx, input logic [10:0] ny, input int delay,
                        input int hold, input bit poke_go, input int abort_after);
    int n;
    int done0;
    int sweep_len;
    bit ls_seen;
    @(negedge clk);
    u_if.go = 1'b1;
    @(negedge clk);
    u_if.go = 1'b0;
    n = 0;
    while (u_if.loc_start !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("loc_start_rise", 32'(u_if.loc_start), 32'd1);
    repeat (delay) begin
      @(negedge clk);
      chk("loc_start_hold", 32'(u_if.loc_start), 32'd1);
    end
    u_if.loc_done = 1'b1;
    u_if.x_loc    = nx;
    u_if.y_loc    = ny;
    sweep_len = mdl_have_prev ? 2 * int'(SIZE * SIZE) : int'(SIZE * SIZE);
    if (mdl_have_prev) push_sweep(mdl_px, mdl_py, 1'b0);
    push_sweep(nx, ny, 1'b1);
    @(negedge clk);
    chk("loc_start_fall", 32'(u_if.loc_start), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("rel_hold", 32'({u_if.busy, u_if.pixel_write, u_if.loc_start}), 32'b100);
    end
    u_if.loc_done = 1'b0;
    u_if.x_loc    = '0;
    u_if.y_loc    = '0;
    done0   = n_done;
    ls_seen = 1'b0;
    n       = 0;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk_outputs_zero("abort_outputs");
      chk("abort_busy", 32'(u_if.busy), 32'd0);
      exp_q.delete();
      mdl_have_prev = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (u_if.loc_start === 1'b1) ls_seen = 1'b1;
      u_if.go = (poke_go && n == sweep_len - 20);
      if (u_if.done === 1'b1) break;
    end
    u_if.go = 1'b0;
    chk("sweep_cycles", 32'(n), 32'(sweep_len + 1));
    mdl_px        = nx;
    mdl_py        = ny;
    mdl_have_prev = 1'b1;
    @(negedge clk);
    chk("done_count", 32'(n_done - done0), 32'd1);
    chk("done_width", 32'(u_if.done), 32'd0);
    chk("busy_after", 32'(u_if.busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("loc_start_quiet", 32'(ls_seen), 32'd0);
    if (poke_go) begin
      repeat (3) @(negedge clk);
      chk("go_ignored", 32'({u_if.busy, u_if.loc_start}), 32'd0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    u_if.go       = 1'b0;
    u_if.loc_done = 1'b0;
    u_if.x_loc    = '0;
    u_if.y_loc    = '0;
    #3 reset = 1'b0;
    #1;
    chk_outputs_zero("reset_outputs");
    chk("reset_busy", 32'(u_if.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_req(11'd100, 11'd200, 3, 0, 1'b0, 0);  // first draw, no erase
    do_req(11'd630, 11'd470, 2, 4, 1'b0, 0);  // erase + clipped draw, long ack
    do_req(11'd300, 11'd100, 1, 0, 1'b1, 0);  // go poked during DRAW
    do_req(11'd50,  11'd60,  0, 0, 1'b0, 300); // reset in DRAW
    do_req(11'd0,   11'd0,   1, 0, 1'b0, 0);  // no erase after reset

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/square_drawer.md
SQUARE_DRAWER -- requirements
Module: square_drawer

Interface
REQ-001 SHALL have parameter SIZE, default 16, square edge length in pixels.
REQ-002 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-004 SHALL have port clk  input  1  the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port go  input  1  request to relocate and draw the square.
REQ-007 SHALL have port loc_start  output  1  location request to the location picker.
REQ-008 SHALL have port loc_done  input  1  location-valid acknowledge from the location picker.
REQ-009 SHALL have port x_loc  input  11  picked top-left x, valid while loc_done=1.
REQ-010 SHALL have port y_loc  input  11  picked top-left y, valid while loc_done=1.
REQ-011 SHALL have port pixel_x  output  11  framebuffer write x.
REQ-012 SHALL have port pixel_y  output  11  framebuffer write y.
REQ-013 SHALL have port pixel_color  output  1  1 = draw, 0 = erase.
REQ-014 SHALL have port pixel_write  output  1  framebuffer write strobe.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL register all outputs and implement states IDLE, REQ, REL, ERASE, DRAW, FIN.
REQ-018 In IDLE, go=1 SHALL move to REQ on the next edge; go SHALL be ignored in every other state.
REQ-019 In REQ, loc_start SHALL be 1 and held until loc_done=1 is sampled, with no timeout.
REQ-020 On the edge sampling loc_done=1 in REQ, the block SHALL latch x_loc/y_loc as new_x/new_y and move to REL.
REQ-021 In REL, loc_start SHALL be 0; leave REL only when loc_done=0 is sampled (four-phase handshake).
REQ-022 On leaving REL, go to ERASE if have_prev=1, else to DRAW.
REQ-023 Sweep order: row-major; cx 0..SIZE-1 is the inner loop, cy 0..SIZE-1 the outer; one pixel per cycle; exactly SIZE*SIZE cycles per sweep.
REQ-024 ERASE SHALL sweep at prev_x+cx, prev_y+cy with pixel_color=0; DRAW SHALL sweep at new_x+cx, new_y+cy with pixel_color=1.
REQ-025 Coordinate sums SHALL be 11-bit unsigned.
REQ-026 Clipping: pixel_write=0 when pixel_x>=SCREEN_W or pixel_y>=SCREEN_H; the cycle still counts toward the sweep.
REQ-027 pixel_write SHALL be 0 outside ERASE/DRAW.
REQ-028 After the last DRAW pixel: prev_x/prev_y<=new_x/new_y, have_prev<=1, enter FIN.
REQ-029 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-030 go held high through FIN SHALL start a new request on the cycle after returning to IDLE.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for clk, force IDLE, all outputs 0, counters 0, prev_x/prev_y 0 and have_prev 0.
REQ-032 Reset mid-sweep SHALL abandon the sweep; the next request SHALL skip ERASE.

Verification
REQ-033 Assert reset=0 mid-cycle -> all outputs 0 before the next clk edge; busy=0.
REQ-034 First go, picker returns (100,200) after 3 cycles -> loc_start=1 until loc_done, then 0; no ERASE; 256 writes, color 1, first (100,200), last (115,215); done pulses once.
REQ-035 Second go, picker returns (630,470) -> 256 erase writes at (100..115, 200..215), then 256 DRAW cycles with only 100 writes (x 630..639, y 470..479).
REQ-036 Pulse go during DRAW -> no effect; exactly one done; loc_start stays 0.
REQ-037 Hold loc_done=1 for 4 cycles after loc_start drops -> block stays in REL, no pixel_write until loc_done=0.
REQ-038 Reset during DRAW, then go with picker returning (0,0) -> no erase writes; 256 draws from (0,0) to (15,15).
